// File: rtl/stage4_defast_dict_ctrl.sv
// -----------------------------------------------------------------------------
// stage4_defast_dict_ctrl
//
// Sequencing controller for the stage-4 FAST header de-copy path. A batch of
// up to three fast-encoded message heads is accepted in one handshake, and the
// present lanes are decoded strictly in order (1, 2, 3). Each lane is decoded
// against the PID/MC/MT copy dictionary as left by the previous lane. Decoded
// headers go out one lane per handshake toward stage 5.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   in_valid/in_ready batch handshake (in_ready high only while idle)
//   in_mask           bit k-1 set = lane k present
//   in_msg_1..3       {pmap[15:0], b0, b1, b2}
//   dict_clr          return the dictionary to INIT values on the next edge
//   out_valid/ready   per-lane output handshake
//   out_lane          lane index 1..3 of the current output
//   out_hdr           decoded {PID, MC, MT}, zero for an illegal pmap
//   out_err           current lane's pmap was illegal
//   dict_pid/mc/mt    current dictionary contents
//   err_cnt           saturating count of illegal pmaps
// -----------------------------------------------------------------------------
module stage4_defast_dict_ctrl #(
  parameter int                 FIELD_W  = 8,
  parameter logic [FIELD_W-1:0] INIT_PID = 8'h11,
  parameter logic [FIELD_W-1:0] INIT_MC  = 8'h22,
  parameter logic [FIELD_W-1:0] INIT_MT  = 8'h33
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [2:0]             in_mask,
  input  logic [16+3*FIELD_W-1:0] in_msg_1,
  input  logic [16+3*FIELD_W-1:0] in_msg_2,
  input  logic [16+3*FIELD_W-1:0] in_msg_3,
  input  logic                   dict_clr,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [1:0]             out_lane,
  output logic [3*FIELD_W-1:0]   out_hdr,
  output logic                   out_err,
  output logic [FIELD_W-1:0]     dict_pid,
  output logic [FIELD_W-1:0]     dict_mc,
  output logic [FIELD_W-1:0]     dict_mt,
  output logic [15:0]            err_cnt
);

  localparam int MSG_W = 16 + 3 * FIELD_W;

  typedef enum logic {IDLE, EMIT} state_t;

  state_t state_reg, state_next;

  logic [MSG_W-1:0]   in_msg_arr [3];
  logic [MSG_W-1:0]   msg_reg    [3];
  logic [2:0]         mask_reg;
  logic [1:0]         lane_reg;
  logic [3*FIELD_W-1:0] hdr_reg;
  logic               err_reg;
  logic [FIELD_W-1:0] dict_pid_reg, dict_mc_reg, dict_mt_reg;
  logic [15:0]        err_cnt_reg;

  logic               in_fire, out_fire, load;
  logic [2:0]         src_mask;
  logic [1:0]         search_after;
  logic [1:0]         next_lane;
  logic [MSG_W-1:0]   sel_msg;
  logic [15:0]        pmap;
  logic [FIELD_W-1:0] pay [3];
  logic               pmap_legal;
  logic               pid_new, mc_new;
  logic [1:0]         mc_idx, mt_idx;
  logic [FIELD_W-1:0] dec_pid, dec_mc, dec_mt;
  logic [3*FIELD_W-1:0] dec_hdr;
  logic               dec_err;

  assign in_msg_arr[0] = in_msg_1;
  assign in_msg_arr[1] = in_msg_2;
  assign in_msg_arr[2] = in_msg_3;

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == EMIT);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  // While idle the first lane is picked straight from the input bus so it can
  // load on the acceptance edge; afterwards the captured copy is used.
  assign src_mask     = (state_reg == IDLE) ? in_mask : mask_reg;
  assign search_after = (state_reg == IDLE) ? 2'd0 : lane_reg;

  // Lowest present lane above the one currently shown (0 = none left).
  always_comb begin
    next_lane = 2'd0;
    for (int k = 3; k >= 1; k--) begin
      if (src_mask[k-1] && (2'(k) > search_after)) begin
        next_lane = 2'(k);
      end
    end
  end

  assign load = ((state_reg == IDLE) ? in_fire : out_fire) && (next_lane != 2'd0);

  always_comb begin
    sel_msg = '0;
    case (next_lane)
      2'd1:    sel_msg = (state_reg == IDLE) ? in_msg_arr[0] : msg_reg[0];
      2'd2:    sel_msg = (state_reg == IDLE) ? in_msg_arr[1] : msg_reg[1];
      2'd3:    sel_msg = (state_reg == IDLE) ? in_msg_arr[2] : msg_reg[2];
      default: sel_msg = '0;
    endcase
  end

  assign pmap = sel_msg[MSG_W-1 -: 16];

  // pay[0] = b0 (just below the pmap), pay[2] = b2.
  for (genvar gi = 0; gi < 3; gi++) begin : g_pay
    assign pay[gi] = sel_msg[(3-gi)*FIELD_W-1 -: FIELD_W];
  end

  assign pmap_legal = pmap[15] && (pmap[11:0] == 12'h000);

  // Present fields are packed from b0 upward, so each field's byte slot is
  // the number of present fields ahead of it.
  assign pid_new = ~pmap[14];
  assign mc_new  = ~pmap[13];
  assign mc_idx  = {1'b0, pid_new};
  assign mt_idx  = {1'b0, pid_new} + {1'b0, mc_new};

  assign dec_pid = pmap[14] ? dict_pid_reg : pay[0];
  assign dec_mc  = pmap[13] ? dict_mc_reg  : pay[mc_idx];
  assign dec_mt  = pmap[12] ? dict_mt_reg  : pay[mt_idx];
  assign dec_err = ~pmap_legal;
  assign dec_hdr = pmap_legal ? {dec_pid, dec_mc, dec_mt} : '0;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (in_fire && (next_lane != 2'd0)) state_next = EMIT;
      EMIT: if (out_fire && (next_lane == 2'd0)) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      msg_reg      <= '{default: '0};
      mask_reg     <= '0;
      lane_reg     <= '0;
      hdr_reg      <= '0;
      err_reg      <= 1'b0;
      dict_pid_reg <= INIT_PID;
      dict_mc_reg  <= INIT_MC;
      dict_mt_reg  <= INIT_MT;
      err_cnt_reg  <= '0;
    end else begin
      state_reg <= state_next;
      if (in_fire) begin
        msg_reg  <= in_msg_arr;
        mask_reg <= in_mask;
      end
      if (load) begin
        lane_reg <= next_lane;
        hdr_reg  <= dec_hdr;
        err_reg  <= dec_err;
        if (dec_err && (err_cnt_reg != 16'hFFFF)) begin
          err_cnt_reg <= err_cnt_reg + 16'd1;
        end
      end
      // A clear on the same edge as a lane load wins for the dictionary; the
      // loaded lane has already been decoded against the old contents.
      if (dict_clr) begin
        dict_pid_reg <= INIT_PID;
        dict_mc_reg  <= INIT_MC;
        dict_mt_reg  <= INIT_MT;
      end else if (load && !dec_err) begin
        dict_pid_reg <= dec_pid;
        dict_mc_reg  <= dec_mc;
        dict_mt_reg  <= dec_mt;
      end
    end
  end

  assign out_lane = lane_reg;
  assign out_hdr  = hdr_reg;
  assign out_err  = err_reg;
  assign dict_pid = dict_pid_reg;
  assign dict_mc  = dict_mc_reg;
  assign dict_mt  = dict_mt_reg;
  assign err_cnt  = err_cnt_reg;

endmodule

// File: tb/tb_stage4_defast_dict_ctrl.sv
// -----------------------------------------------------------------------------
// tb_stage4_defast_dict_ctrl
//
// Directed batches followed by randomized traffic, all checked every cycle
// against a queue-based reference model of the decode/dictionary rules.
// -----------------------------------------------------------------------------
module tb_stage4_defast_dict_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_mask;
  logic [39:0] in_msg_1, in_msg_2, in_msg_3;
  logic        dict_clr;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_lane;
  logic [23:0] out_hdr;
  logic        out_err;
  logic [7:0]  dict_pid, dict_mc, dict_mt;
  logic [15:0] err_cnt;

  stage4_defast_dict_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mask   (in_mask),
    .in_msg_1  (in_msg_1),
    .in_msg_2  (in_msg_2),
    .in_msg_3  (in_msg_3),
    .dict_clr  (dict_clr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_lane  (out_lane),
    .out_hdr   (out_hdr),
    .out_err   (out_err),
    .dict_pid  (dict_pid),
    .dict_mc   (dict_mc),
    .dict_mt   (dict_mt),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  localparam logic [23:0] INIT_DICT = 24'h112233;

  bit          m_busy;
  int          q_lane[$];
  logic [39:0] q_msg[$];
  int          m_lane;
  logic [23:0] m_hdr;
  logic        m_err;
  logic [23:0] m_dict;
  int          m_errcnt;

  function automatic logic [39:0] mk(input logic [15:0] pm, input logic [7:0] b0,
                                     input logic [7:0] b1, input logic [7:0] b2);
    return {pm, b0, b1, b2};
  endfunction

  // Fields PID, MC, MT in order; a cleared copy flag takes the next unused byte.
  function automatic void ref_decode(input logic [39:0] msg, input logic [23:0] dict,
                                     output logic [23:0] hdr, output logic err);
    logic [15:0] pm;
    logic [7:0]  b[3];
    logic [7:0]  d[3];
    logic [7:0]  f[3];
    int          k;
    pm = msg[39:24];
    b[0] = msg[23:16]; b[1] = msg[15:8]; b[2] = msg[7:0];
    d[0] = dict[23:16]; d[1] = dict[15:8]; d[2] = dict[7:0];
    k = 0;
    for (int i = 0; i < 3; i++) begin
      if (pm[14-i]) f[i] = d[i];
      else begin
        f[i] = b[k];
        k++;
      end
    end
    err = !(pm[15] == 1'b1 && pm[11:0] == 12'h000);
    hdr = err ? 24'h0 : {f[0], f[1], f[2]};
  endfunction

  task automatic model_reset();
    m_busy = 0;
    q_lane.delete();
    q_msg.delete();
    m_lane = 0;
    m_hdr = '0;
    m_err = 0;
    m_dict = INIT_DICT;
    m_errcnt = 0;
  endtask

  task automatic model_load(output bit upd, output logic [23:0] nd);
    logic [39:0] msg;
    msg = q_msg.pop_front();
    m_lane = q_lane.pop_front();
    ref_decode(msg, m_dict, m_hdr, m_err);
    upd = !m_err;
    nd = m_hdr;
    if (m_err && m_errcnt < 65535) m_errcnt++;
  endtask

  // Called right after an active edge with the inputs that edge sampled.
  task automatic model_edge();
    bit          upd;
    logic [23:0] nd;
    logic [39:0] msgs[3];
    upd = 0;
    nd = '0;
    if (!m_busy) begin
      if (in_valid) begin
        msgs[0] = in_msg_1; msgs[1] = in_msg_2; msgs[2] = in_msg_3;
        for (int l = 1; l <= 3; l++) begin
          if (in_mask[l-1]) begin
            q_lane.push_back(l);
            q_msg.push_back(msgs[l-1]);
          end
        end
        $display("batch accepted mask=%b", in_mask);
        if (q_lane.size() != 0) begin
          model_load(upd, nd);
          m_busy = 1;
        end
      end
    end else if (out_ready) begin
      $display("beat lane=%0d hdr=%h err=%0d", m_lane, m_hdr, m_err);
      if (q_lane.size() != 0) model_load(upd, nd);
      else m_busy = 0;
    end
    if (dict_clr) m_dict = INIT_DICT;
    else if (upd) m_dict = nd;
  endtask

  task automatic compare_all();
    check_val("in_ready", in_ready, !m_busy);
    check_val("out_valid", out_valid, m_busy);
    check_val("dict", {dict_pid, dict_mc, dict_mt}, m_dict);
    check_val("err_cnt", err_cnt, m_errcnt);
    if (m_busy) begin
      check_val("out_lane", out_lane, m_lane);
      check_val("out_hdr", out_hdr, m_hdr);
      check_val("out_err", out_err, m_err);
    end
  endtask

  // Inputs are set at the falling edge; DUT and model both see them at the
  // rising edge, outputs are compared 1ns later.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
    @(negedge clk);
  endtask

  task automatic send_batch(input logic [2:0] mask, input logic [39:0] a,
                            input logic [39:0] b, input logic [39:0] c);
    in_valid = 1; in_mask = mask;
    in_msg_1 = a; in_msg_2 = b; in_msg_3 = c;
    step();
    in_valid = 0;
    in_msg_1 = $urandom; in_msg_2 = $urandom; in_msg_3 = $urandom;
  endtask

  task automatic drain();
    int n;
    n = 0;
    out_ready = 1;
    while (m_busy && n < 50) begin
      step();
      n++;
    end
    if (n >= 50) check_val("drain_timeout", 1, 0);
  endtask

  // Reset asserted between edges: its effect must be visible before the next edge.
  task automatic async_reset();
    #2 rst_n = 0;
    #1;
    model_reset();
    check_val("rst_out_valid", out_valid, 0);
    check_val("rst_in_ready", in_ready, 1);
    check_val("rst_out_lane", out_lane, 0);
    check_val("rst_out_hdr", out_hdr, 0);
    check_val("rst_out_err", out_err, 0);
    check_val("rst_dict", {dict_pid, dict_mc, dict_mt}, INIT_DICT);
    check_val("rst_err_cnt", err_cnt, 0);
    #1 rst_n = 1;
  endtask

  initial begin
    rst_n = 0; in_valid = 0; in_mask = 0; dict_clr = 0; out_ready = 0;
    in_msg_1 = 0; in_msg_2 = 0; in_msg_3 = 0;
    model_reset();
    #12;
    check_val("rst_out_valid", out_valid, 0);
    check_val("rst_in_ready", in_ready, 1);
    check_val("rst_out_lane", out_lane, 0);
    check_val("rst_out_hdr", out_hdr, 0);
    check_val("rst_out_err", out_err, 0);
    check_val("rst_dict", {dict_pid, dict_mc, dict_mt}, INIT_DICT);
    check_val("rst_err_cnt", err_cnt, 0);
    @(negedge clk);
    rst_n = 1;

    // Three chained lanes.
    out_ready = 1;
    send_batch(3'b111, mk(16'hB000, 8'h45, 8'h00, 8'h00),
               mk(16'hF000, 8'h01, 8'h02, 8'h03),
               mk(16'h9000, 8'hAA, 8'hBB, 8'hCC));
    drain();
    check_val("tp1_dict", {dict_pid, dict_mc, dict_mt}, 24'hAABB33);

    // Sparse mask: lane 2 skipped.
    send_batch(3'b101, mk(16'h8000, 8'h01, 8'h02, 8'h03),
               mk(16'h8000, 8'hDE, 8'hAD, 8'hBE),
               mk(16'hE000, 8'h77, 8'h00, 8'h00));
    drain();

    // Illegal pmap.
    send_batch(3'b001, mk(16'h8800, 8'h55, 8'h66, 8'h77), 40'h0, 40'h0);
    drain();

    // Empty batch.
    send_batch(3'b000, mk(16'h8000, 8'h12, 8'h34, 8'h56), 40'h0, 40'h0);
    step();

    // Backpressure on lane 1.
    out_ready = 0;
    send_batch(3'b011, mk(16'h8000, 8'h10, 8'h20, 8'h30),
               mk(16'hC000, 8'h40, 8'h50, 8'h00), 40'h0);
    repeat (5) step();
    drain();

    // Clear on the edge that loads lane 2.
    out_ready = 0;
    send_batch(3'b111, mk(16'h8000, 8'h01, 8'h02, 8'h03),
               mk(16'hB000, 8'h99, 8'h00, 8'h00),
               mk(16'hF000, 8'h00, 8'h00, 8'h00));
    out_ready = 1; dict_clr = 1;
    step();
    dict_clr = 0;
    check_val("clr_lane2_hdr", out_hdr, 24'h990203);
    drain();

    // Reset during lane 2.
    send_batch(3'b111, mk(16'h8000, 8'h0A, 8'h0B, 8'h0C),
               mk(16'h8800, 8'h00, 8'h00, 8'h00),
               mk(16'h8000, 8'h0D, 8'h0E, 8'h0F));
    step();
    async_reset();
    out_ready = 1;
    repeat (3) step();

    // Randomized traffic.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic [39:0] r[3];
      for (int i = 0; i < 3; i++) begin
        r[i] = {($urandom_range(0, 9) != 0) ? 1'b1 : 1'b0, 3'($urandom),
                ($urandom_range(0, 9) == 0) ? 12'($urandom) : 12'h000,
                8'($urandom), 8'($urandom), 8'($urandom)};
      end
      in_valid  = ($urandom_range(0, 1) == 1);
      in_mask   = 3'($urandom);
      in_msg_1  = r[0]; in_msg_2 = r[1]; in_msg_3 = r[2];
      out_ready = ($urandom_range(0, 9) < 7);
      dict_clr  = ($urandom_range(0, 9) == 0);
      if (m_busy && $urandom_range(0, 199) == 0) async_reset();
      step();
    end
    in_valid = 0; dict_clr = 0;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
